// File: rtl/router_register_gen.sv
// router_register_gen
// Packet register stage between the router input FSM and the output FIFOs.
// Captures the header, keeps the byte that a full FIFO refused, and drives dout
// one cycle after each load. Alongside the data it accumulates an XOR parity or
// an additive checksum, counts payload bytes against the header length field,
// and flags illegal destination addresses.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   pkt_valid, data_in     packet byte stream (pkt_valid low on the check byte)
//   fifo_full              selected FIFO is full
//   rst_int_reg            FSM request to clear low_pkt_valid
//   detect_add, lfd_state, ld_state, laf_state, full_state   FSM state decodes
//   dout, dout_valid       byte to FIFO and its write qualifier
//   parity_done            check byte has been received
//   low_pkt_valid          pkt_valid was seen low during ld_state
//   err                    check value mismatch
//   len_err                payload byte count differs from header length
//   addr_err               header destination >= NUM_CH
module router_register_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned CHK_MODE   = 0,
  parameter int unsigned CHECK_LEN  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  rst_int_reg,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic                  len_err,
  output logic                  addr_err
);

  localparam int unsigned LEN_W = DATA_WIDTH - ADDR_W;

  logic [DATA_WIDTH-1:0] hdr_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] pkt_chk;
  logic [DATA_WIDTH-1:0] int_chk;
  logic [LEN_W-1:0]      pay_cnt;
  logic                  addr_illegal_c;
  logic                  count_byte_c;
  logic [LEN_W-1:0]      hdr_len_c;

  // One extra bit so NUM_CH == 2**ADDR_W compares correctly.
  assign addr_illegal_c = {1'b0, data_in[ADDR_W-1:0]} >= (ADDR_W+1)'(NUM_CH);
  // Payload bytes only: the check byte arrives with pkt_valid low.
  assign count_byte_c   = pkt_valid && ld_state && !full_state;
  assign hdr_len_c      = hdr_reg[DATA_WIDTH-1:ADDR_W];

  // Check accumulation operator: XOR parity or modular sum.
  function automatic logic [DATA_WIDTH-1:0] chk_op(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    if (CHK_MODE == 0) return a ^ b;
    else               return a + b;
  endfunction

  // Header capture; an illegal destination leaves the previous header in place.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hdr_reg  <= '0;
      addr_err <= 1'b0;
    end else if (pkt_valid && detect_add) begin
      addr_err <= addr_illegal_c;
      if (!addr_illegal_c) hdr_reg <= data_in;
    end
  end

  // Byte refused by a full FIFO, replayed in laf_state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       hold_reg <= '0;
    else if (ld_state && fifo_full)  hold_reg <= data_in;
  end

  // Output byte and write qualifier.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (lfd_state) begin
      dout       <= hdr_reg;
      dout_valid <= 1'b1;
    end else if (ld_state && !fifo_full) begin
      dout       <= data_in;
      dout_valid <= 1'b1;
    end else if (laf_state) begin
      dout       <= hold_reg;
      dout_valid <= 1'b1;
    end else begin
      dout_valid <= 1'b0;
    end
  end

  // Received check byte; captured even while the FIFO is full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       pkt_chk <= '0;
    else if (ld_state && !pkt_valid) pkt_chk <= data_in;
  end

  // Running check value and payload counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int_chk <= '0;
      pay_cnt <= '0;
    end else if (detect_add) begin
      int_chk <= '0;
      pay_cnt <= '0;
    end else begin
      if (lfd_state)         int_chk <= chk_op(int_chk, hdr_reg);
      else if (count_byte_c) int_chk <= chk_op(int_chk, data_in);
      if (count_byte_c && (pay_cnt != '1)) pay_cnt <= pay_cnt + LEN_W'(1);
    end
  end

  // Sticky end-of-packet indicator; the FSM clear wins over a new set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       low_pkt_valid <= 1'b0;
    else if (rst_int_reg)            low_pkt_valid <= 1'b0;
    else if (ld_state && !pkt_valid) low_pkt_valid <= 1'b1;
  end

  // Check byte received, either directly or via the laf replay path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      parity_done <= 1'b0;
    else if (detect_add)
      parity_done <= 1'b0;
    else if ((ld_state && !fifo_full && !pkt_valid) ||
             (laf_state && low_pkt_valid && !parity_done))
      parity_done <= 1'b1;
  end

  // Error flags evaluated while parity_done is high and held otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err     <= 1'b0;
      len_err <= 1'b0;
    end else if (parity_done) begin
      err     <= (int_chk != pkt_chk);
      len_err <= (CHECK_LEN != 0) && (pay_cnt != hdr_len_c);
    end
  end

endmodule

// File: tb/tb_router_register_gen.sv
// tb_router_register_gen
// Drives two instances (XOR parity and additive checksum) with one stimulus
// stream and compares both against hand-computed per-cycle expectations.
module tb_router_register_gen;

  localparam logic [4:0] IDL = 5'b00000;
  localparam logic [4:0] DA  = 5'b10000;
  localparam logic [4:0] LFD = 5'b01000;
  localparam logic [4:0] LD  = 5'b00100;
  localparam logic [4:0] LAF = 5'b00010;
  localparam logic [4:0] FUL = 5'b00001;

  // st = {detect_add, lfd, ld, laf, full}; ctl = {pkt_valid, fifo_full, rst_int_reg}
  // fl = {dout_valid, parity_done, low_pkt_valid, err(mode0), err(mode1), len_err, addr_err}
  typedef struct {
    logic [4:0] st;
    logic [2:0] ctl;
    logic [7:0] din;
    logic [7:0] dout;
    logic [6:0] fl;
  } vec_t;

  logic       clock, reset;
  logic       pkt_valid, fifo_full, rst_int_reg;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic [7:0] data_in;
  logic [7:0] dout0, dout1;
  logic       dv0, dv1, pd0, pd1, lpv0, lpv1, err0, err1, lerr0, lerr1, aerr0, aerr1;

  int checks   = 0;
  int failures = 0;
  vec_t vq[$];
  logic [7:0] pay_mem [0:127];

  router_register_gen #(.DATA_WIDTH(8), .ADDR_W(2), .NUM_CH(3), .CHK_MODE(0), .CHECK_LEN(1)) dut0 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .dout(dout0), .dout_valid(dv0), .parity_done(pd0), .low_pkt_valid(lpv0),
    .err(err0), .len_err(lerr0), .addr_err(aerr0));

  router_register_gen #(.DATA_WIDTH(8), .ADDR_W(2), .NUM_CH(3), .CHK_MODE(1), .CHECK_LEN(1)) dut1 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .dout(dout1), .dout_valid(dv1), .parity_done(pd1), .low_pkt_valid(lpv1),
    .err(err1), .len_err(lerr1), .addr_err(aerr1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [4:0] st, input logic [2:0] ctl, input logic [7:0] din,
                              input logic [7:0] dout, input logic [6:0] fl);
    vec_t v;
    v.st = st; v.ctl = ctl; v.din = din; v.dout = dout; v.fl = fl;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, return 1 time unit after the rising edge.
  task automatic step(input logic [4:0] st, input logic [2:0] ctl, input logic [7:0] din);
    @(negedge clock);
    {detect_add, lfd_state, ld_state, laf_state, full_state} = st;
    {pkt_valid, fifo_full, rst_int_reg} = ctl;
    data_in = din;
    @(posedge clock);
    #1;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    cmp("dout0", idx, dout0, v.dout);
    cmp("dout1", idx, dout1, v.dout);
    cmp("dout_valid0", idx, 8'(dv0), 8'(v.fl[6]));
    cmp("dout_valid1", idx, 8'(dv1), 8'(v.fl[6]));
    cmp("parity_done0", idx, 8'(pd0), 8'(v.fl[5]));
    cmp("parity_done1", idx, 8'(pd1), 8'(v.fl[5]));
    cmp("low_pkt_valid0", idx, 8'(lpv0), 8'(v.fl[4]));
    cmp("low_pkt_valid1", idx, 8'(lpv1), 8'(v.fl[4]));
    cmp("err_xor", idx, 8'(err0), 8'(v.fl[3]));
    cmp("err_sum", idx, 8'(err1), 8'(v.fl[2]));
    cmp("len_err0", idx, 8'(lerr0), 8'(v.fl[1]));
    cmp("len_err1", idx, 8'(lerr1), 8'(v.fl[1]));
    cmp("addr_err0", idx, 8'(aerr0), 8'(v.fl[0]));
    cmp("addr_err1", idx, 8'(aerr1), 8'(v.fl[0]));
  endtask

  task automatic check_zero(input int idx);
    cmp("rst_dout0", idx, dout0, 8'h00);
    cmp("rst_dout1", idx, dout1, 8'h00);
    cmp("rst_flags0", idx, 8'({dv0, pd0, lpv0, err0, lerr0, aerr0}), 8'h00);
    cmp("rst_flags1", idx, 8'({dv1, pd1, lpv1, err1, lerr1, aerr1}), 8'h00);
  endtask

  // Full packet with payload from pay_mem, then result flags after the error latency.
  task automatic run_pkt(input int tag, input logic [7:0] hdr, input int n, input logic [7:0] chk,
                         input logic e0, input logic e1, input logic le);
    step(DA, 3'b100, hdr);
    step(LFD, 3'b100, 8'h00);
    for (int i = 0; i < n; i++) step(LD, 3'b100, pay_mem[i]);
    step(LD, 3'b000, chk);
    step(IDL, 3'b001, 8'h00);
    step(IDL, 3'b000, 8'h00);
    cmp("pkt_parity_done", tag, 8'(pd0), 8'h01);
    cmp("pkt_err_xor", tag, 8'(err0), 8'(e0));
    cmp("pkt_err_sum", tag, 8'(err1), 8'(e1));
    cmp("pkt_len_err0", tag, 8'(lerr0), 8'(le));
    cmp("pkt_len_err1", tag, 8'(lerr1), 8'(le));
    cmp("pkt_addr_err", tag, 8'(aerr0), 8'h00);
  endtask

  initial begin
    // clean packet hdr 0D (addr 1, L 3), payload 11 22 33, check 0D
    vq.push_back(mk(DA,  3'b100, 8'h0D, 8'h00, 7'b0000000));
    vq.push_back(mk(LFD, 3'b100, 8'h11, 8'h0D, 7'b1000000));
    vq.push_back(mk(LD,  3'b100, 8'h11, 8'h11, 7'b1000000));
    vq.push_back(mk(LD,  3'b100, 8'h22, 8'h22, 7'b1000000));
    vq.push_back(mk(LD,  3'b100, 8'h33, 8'h33, 7'b1000000));
    vq.push_back(mk(LD,  3'b000, 8'h0D, 8'h0D, 7'b1110000));
    vq.push_back(mk(IDL, 3'b001, 8'h00, 8'h0D, 7'b0100100));
    vq.push_back(mk(IDL, 3'b000, 8'h00, 8'h0D, 7'b0100100));
    // bad check byte 0E; next header clears parity_done, err held
    vq.push_back(mk(DA,  3'b100, 8'h0D, 8'h0D, 7'b0000100));
    vq.push_back(mk(LFD, 3'b100, 8'h11, 8'h0D, 7'b1000100));
    vq.push_back(mk(LD,  3'b100, 8'h11, 8'h11, 7'b1000100));
    vq.push_back(mk(LD,  3'b100, 8'h22, 8'h22, 7'b1000100));
    vq.push_back(mk(LD,  3'b100, 8'h33, 8'h33, 7'b1000100));
    vq.push_back(mk(LD,  3'b000, 8'h0E, 8'h0E, 7'b1110100));
    vq.push_back(mk(IDL, 3'b001, 8'h00, 8'h0E, 7'b0101100));
    // hdr 11 (L 4) with only 3 payload bytes
    vq.push_back(mk(DA,  3'b100, 8'h11, 8'h0E, 7'b0001100));
    vq.push_back(mk(LFD, 3'b100, 8'h11, 8'h11, 7'b1001100));
    vq.push_back(mk(LD,  3'b100, 8'h11, 8'h11, 7'b1001100));
    vq.push_back(mk(LD,  3'b100, 8'h22, 8'h22, 7'b1001100));
    vq.push_back(mk(LD,  3'b100, 8'h33, 8'h33, 7'b1001100));
    vq.push_back(mk(LD,  3'b000, 8'h11, 8'h11, 7'b1111100));
    vq.push_back(mk(IDL, 3'b001, 8'h00, 8'h11, 7'b0100110));
    // FIFO full on 0x22, replayed through laf_state
    vq.push_back(mk(DA,  3'b100, 8'h0D, 8'h11, 7'b0000110));
    vq.push_back(mk(LFD, 3'b100, 8'h11, 8'h0D, 7'b1000110));
    vq.push_back(mk(LD,  3'b100, 8'h11, 8'h11, 7'b1000110));
    vq.push_back(mk(LD,  3'b110, 8'h22, 8'h11, 7'b0000110));
    vq.push_back(mk(FUL, 3'b110, 8'h22, 8'h11, 7'b0000110));
    vq.push_back(mk(LAF, 3'b100, 8'h22, 8'h22, 7'b1000110));
    vq.push_back(mk(LD,  3'b100, 8'h33, 8'h33, 7'b1000110));
    vq.push_back(mk(LD,  3'b000, 8'h0D, 8'h0D, 7'b1110110));
    vq.push_back(mk(IDL, 3'b001, 8'h00, 8'h0D, 7'b0100100));
    // illegal address 3 keeps hdr_reg; address 2 is the last legal one
    vq.push_back(mk(DA,  3'b100, 8'h0F, 8'h0D, 7'b0000101));
    vq.push_back(mk(LFD, 3'b100, 8'h00, 8'h0D, 7'b1000101));
    vq.push_back(mk(DA,  3'b100, 8'h0D, 8'h0D, 7'b0000100));
    vq.push_back(mk(DA,  3'b100, 8'h0E, 8'h0D, 7'b0000100));
    vq.push_back(mk(LFD, 3'b100, 8'h00, 8'h0E, 7'b1000100));
    // check byte arrives while full: parity_done set via laf_state
    vq.push_back(mk(DA,  3'b100, 8'h06, 8'h0E, 7'b0000100));
    vq.push_back(mk(LFD, 3'b100, 8'hAA, 8'h06, 7'b1000100));
    vq.push_back(mk(LD,  3'b100, 8'hAA, 8'hAA, 7'b1000100));
    vq.push_back(mk(LD,  3'b010, 8'hAC, 8'hAA, 7'b0010100));
    vq.push_back(mk(FUL, 3'b010, 8'hAC, 8'hAA, 7'b0010100));
    vq.push_back(mk(LAF, 3'b000, 8'hAC, 8'hAC, 7'b1110100));
    vq.push_back(mk(IDL, 3'b001, 8'h00, 8'hAC, 7'b0100100));
    // rst_int_reg beats a low_pkt_valid set; pkt_chk captured under full
    vq.push_back(mk(LD,  3'b011, 8'h55, 8'hAC, 7'b0100100));
    vq.push_back(mk(IDL, 3'b000, 8'h00, 8'hAC, 7'b0101100));
    // detect_add together with a check byte: parity_done clear wins
    vq.push_back(mk(DA | LD, 3'b000, 8'h0D, 8'h0D, 7'b1011100));
    vq.push_back(mk(IDL, 3'b000, 8'h00, 8'h0D, 7'b0011100));
    vq.push_back(mk(IDL, 3'b001, 8'h00, 8'h0D, 7'b0001100));

    {detect_add, lfd_state, ld_state, laf_state, full_state} = 5'b0;
    {pkt_valid, fifo_full, rst_int_reg} = 3'b0;
    data_in = 8'h00;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_zero(-1);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].st, vq[i].ctl, vq[i].din);
      check_vec(i, vq[i]);
    end

    // checksum mode: 0D+11+22+33 = 73
    pay_mem[0] = 8'h11; pay_mem[1] = 8'h22; pay_mem[2] = 8'h33;
    run_pkt(100, 8'h0D, 3, 8'h73, 1'b1, 1'b0, 1'b0);
    run_pkt(101, 8'h0D, 3, 8'h0D, 1'b0, 1'b1, 1'b0);

    // payload counter saturation at L = 63
    for (int i = 0; i < 128; i++) pay_mem[i] = 8'h00;
    run_pkt(102, 8'hFD, 70, 8'hFD, 1'b0, 1'b0, 1'b0);
    run_pkt(103, 8'hFD, 62, 8'hFD, 1'b0, 1'b0, 1'b1);

    // asynchronous reset mid-payload, then a clean packet
    step(DA, 3'b100, 8'h0D);
    step(LFD, 3'b100, 8'h11);
    step(LD, 3'b100, 8'h11);
    step(LD, 3'b100, 8'h22);
    cmp("pre_reset_dout", 200, dout0, 8'h22);
    #2 reset = 1'b1;
    #1 check_zero(201);
    @(negedge clock);
    reset = 1'b0;
    {detect_add, lfd_state, ld_state, laf_state, full_state} = 5'b0;
    {pkt_valid, fifo_full, rst_int_reg} = 3'b0;
    for (int i = 0; i < 8; i++) begin
      step(vq[i].st, vq[i].ctl, vq[i].din);
      check_vec(300 + i, vq[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
